// File: rtl/proj_fm_feeder.sv
// proj_fm_feeder: write-side feeder for the double-buffered fragment memory; PROJ_FM_FEEDER_FLUSH_EN adds zero-pad flush
module proj_fm_feeder #(
    parameter int DATA_BITS      = 32,
    parameter int FM_BUFFER_SIZE = 16,
    parameter int KMER_LEN       = 4,
    parameter int CNT_W          = $clog2(FM_BUFFER_SIZE + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [DATA_BITS-1:0] in_data,
    output logic                 in_ready,
    output logic [DATA_BITS-1:0] out_wdata,
    output logic                 out_wvalid,
    output logic                 chg_idx,
    input  logic                 cons_done,
    input  logic                 flush,
    output logic [CNT_W-1:0]     word_cnt,
    output logic                 rd_busy,
    output logic                 err
);
    localparam int SW = $clog2(KMER_LEN + 1);

    typedef enum logic [1:0] {FILL, SETTLE, WAIT_RD, SWAP} state_t;

    state_t        state, state_nx;
    logic [SW-1:0] set_cnt;
    logic          pad, wr, last_wr, set_last, rd_free;

`ifdef PROJ_FM_FEEDER_FLUSH_EN
    logic flushing;
    assign pad = (state == FILL) && (flushing || (flush && word_cnt != '0));
`else
    logic unused_flush;
    assign unused_flush = flush;
    assign pad = 1'b0;
`endif

    assign in_ready = (state == FILL) && !pad;
    assign wr       = (in_valid && in_ready) || pad;
    assign last_wr  = wr && (word_cnt == CNT_W'(FM_BUFFER_SIZE - 1));
    assign set_last = set_cnt == SW'(KMER_LEN - 1);
    // a release arriving this cycle lets the swap go ahead on the next one
    assign rd_free  = !rd_busy || cons_done;
    assign chg_idx  = state == SWAP;

    always_comb begin
        state_nx = state;
        case (state)
            FILL:    state_nx = last_wr ? SETTLE : FILL;
            SETTLE:  state_nx = !set_last ? SETTLE : (rd_free ? SWAP : WAIT_RD);
            WAIT_RD: state_nx = rd_free ? SWAP : WAIT_RD;
            default: state_nx = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FILL;
            set_cnt    <= '0;
            word_cnt   <= '0;
            out_wvalid <= 1'b0;
            out_wdata  <= '0;
            rd_busy    <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_nx;
            set_cnt    <= (state == SETTLE) ? set_cnt + SW'(1) : '0;
            word_cnt   <= (state == SWAP) ? '0 : word_cnt + CNT_W'(wr);
            out_wvalid <= wr;
            if (wr)
                out_wdata <= pad ? '0 : in_data;
            rd_busy    <= (state == SWAP) || (rd_busy && !cons_done);
            err        <= err || (cons_done && !rd_busy && state != SWAP);
        end
    end

`ifdef PROJ_FM_FEEDER_FLUSH_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            flushing <= 1'b0;
        else
            flushing <= pad && !last_wr;
    end
`endif
endmodule

// File: tb/tb_proj_fm_feeder.sv
// tb_proj_fm_feeder: vector table plus randomized run against a timing-rule reference model
module tb_proj_fm_feeder;
    localparam int N = 8;
    localparam int K = 2;
`ifdef PROJ_FM_FEEDER_FLUSH_EN
    localparam bit FLUSH = 1'b1;
`else
    localparam bit FLUSH = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_ready;
    logic [7:0] out_wdata;
    logic       out_wvalid;
    logic       chg_idx;
    logic       cons_done = 1'b0;
    logic       flush = 1'b0;
    logic [3:0] word_cnt;
    logic       rd_busy;
    logic       err;

    proj_fm_feeder #(.DATA_BITS(8), .FM_BUFFER_SIZE(N), .KMER_LEN(K)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_wdata(out_wdata), .out_wvalid(out_wvalid),
        .chg_idx(chg_idx), .cons_done(cons_done), .flush(flush),
        .word_cnt(word_cnt), .rd_busy(rd_busy), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // model: buffer occupancy, edge of the last write, reader hold, error flag
    int         m_cnt;
    int         m_full_t;
    bit         m_busy, m_err, m_wv, m_pad;
    logic [7:0] m_wd;
    bit         e_ready, e_swap, e_pad;

    typedef struct {
        logic        vi;
        logic [7:0]  d;
        logic        cd;
        logic [16:0] exp;
    } vec_t;
    vec_t tbl[15];

    function automatic logic [16:0] mk(bit r, bit wv, logic [7:0] wd, bit c, logic [3:0] n, bit b, bit e);
        return {r, wv, wd, c, n, b, e};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic eval();
        e_pad   = FLUSH && m_cnt < N && (m_pad || (flush && m_cnt > 0));
        e_ready = m_cnt < N && !e_pad;
        e_swap  = m_cnt == N && cyc >= m_full_t + K && !m_busy;
    endtask

    task automatic compare();
        chk("in_ready", 32'(in_ready), 32'(e_ready));
        chk("out_wvalid", 32'(out_wvalid), 32'(m_wv));
        chk("out_wdata", 32'(out_wdata), 32'(m_wd));
        chk("chg_idx", 32'(chg_idx), 32'(e_swap));
        chk("word_cnt", 32'(word_cnt), 32'(m_cnt));
        chk("rd_busy", 32'(rd_busy), 32'(m_busy));
        chk("err", 32'(err), 32'(m_err));
    endtask

    task automatic drive(input logic vi, input logic [7:0] d, input logic cd, input logic fl);
        in_valid = vi;
        in_data = d;
        cons_done = cd;
        flush = fl;
        eval();
        #1;
        compare();
    endtask

    task automatic tick();
        bit wr;
        @(posedge clk);
        wr = e_pad || (in_valid && e_ready);
        m_wv = wr;
        if (wr) begin
            m_wd = e_pad ? 8'h00 : in_data;
            m_cnt++;
            if (m_cnt == N)
                m_full_t = cyc + 1;
        end
        if (e_swap) begin
            m_cnt = 0;
            m_busy = 1'b1;
        end else if (cons_done) begin
            if (m_busy)
                m_busy = 1'b0;
            else
                m_err = 1'b1;
        end
        m_pad = e_pad && m_cnt < N;
        cyc++;
        @(negedge clk);
    endtask

    // asserted mid-cycle so the async clear is visible before any edge
    task automatic do_reset();
        in_valid = 1'b0;
        cons_done = 1'b0;
        flush = 1'b0;
        rst_n = 1'b0;
        m_cnt = 0; m_full_t = 0; m_busy = 0; m_err = 0; m_wv = 0; m_pad = 0; m_wd = '0;
        eval();
        #1;
        compare();
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
    endtask

    task automatic run(input int n, input int pv, input int pcd, input int pfl);
        for (int i = 0; i < n; i++) begin
            drive($urandom_range(99) < pv, 8'($urandom), $urandom_range(99) < pcd, $urandom_range(99) < pfl);
            tick();
        end
    endtask

    initial begin
        tbl[0]  = '{1'b1, 8'h11, 1'b1, mk(1, 0, 8'h00, 0, 0, 0, 0)};
        tbl[1]  = '{1'b1, 8'h22, 1'b0, mk(1, 1, 8'h11, 0, 1, 0, 1)};
        tbl[2]  = '{1'b0, 8'h33, 1'b0, mk(1, 1, 8'h22, 0, 2, 0, 1)};
        tbl[3]  = '{1'b1, 8'h44, 1'b0, mk(1, 0, 8'h22, 0, 2, 0, 1)};
        tbl[4]  = '{1'b1, 8'h55, 1'b0, mk(1, 1, 8'h44, 0, 3, 0, 1)};
        tbl[5]  = '{1'b1, 8'h66, 1'b0, mk(1, 1, 8'h55, 0, 4, 0, 1)};
        tbl[6]  = '{1'b1, 8'h77, 1'b0, mk(1, 1, 8'h66, 0, 5, 0, 1)};
        tbl[7]  = '{1'b1, 8'h88, 1'b0, mk(1, 1, 8'h77, 0, 6, 0, 1)};
        tbl[8]  = '{1'b1, 8'h99, 1'b0, mk(1, 1, 8'h88, 0, 7, 0, 1)};
        tbl[9]  = '{1'b1, 8'haa, 1'b0, mk(0, 1, 8'h99, 0, 8, 0, 1)};
        tbl[10] = '{1'b1, 8'hbb, 1'b0, mk(0, 0, 8'h99, 0, 8, 0, 1)};
        tbl[11] = '{1'b0, 8'hcc, 1'b1, mk(0, 0, 8'h99, 1, 8, 0, 1)};
        tbl[12] = '{1'b0, 8'h00, 1'b0, mk(1, 0, 8'h99, 0, 0, 1, 1)};
        tbl[13] = '{1'b0, 8'h00, 1'b1, mk(1, 0, 8'h99, 0, 0, 1, 1)};
        tbl[14] = '{1'b0, 8'h00, 1'b0, mk(1, 0, 8'h99, 0, 0, 0, 1)};

        @(negedge clk);
        do_reset();
        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].vi, tbl[i].d, tbl[i].cd, 1'b0);
            chk($sformatf("row%0d", i), 32'({in_ready, out_wvalid, out_wdata, chg_idx, word_cnt, rd_busy, err}), 32'(tbl[i].exp));
            tick();
        end

        // two fills with the reader never releasing, then one release
        do_reset();
        run(45, 100, 0, 0);
        chk("blocked_ready", 32'(in_ready), 32'(0));
        run(1, 0, 100, 0);
        chk("swap_after_release", 32'(chg_idx), 32'(1));
        run(12, 100, 0, 0);

        // bubbles and sporadic releases
        run(80, 50, 10, 0);

        // reset in the middle of a fill
        do_reset();
        for (int i = 0; i < 20 && m_cnt != 5; i++) begin
            drive(1'b1, 8'($urandom), 1'b0, 1'b0);
            tick();
        end
        chk("cnt5", 32'(word_cnt), 32'(5));
        do_reset();
        run(30, 100, 15, 0);

        // flush after three words
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'($urandom), 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 8'h5a, 1'b0, 1'b1);
        tick();
        run(30, 100, 0, 0);

        run(2000, 70, 8, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
